vga_digit_overlay: RTL and testbench

// - Renders a 4-digit BCD seconds counter as a 12x16 glyph overlay on the VGA pixel stream.
// - Sits between the VGA timing generator (upstream) and the DAC pins (downstream).
// - Drives the address of the font ROM (glyph rows, 16 per digit 0-9, 160 words) and consumes its registered output.
// - Outputs pixel colour plus sync signals, delay-matched to the colour.

---
 rtl/vga_pkg.sv | 52 +++++
 rtl/bcd_counter.sv | 43 ++++
 rtl/vga_digit_overlay.sv | 196 +++++++++++++++++++
 tb/tb_vga_digit_overlay.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package : vga_pkg
// Brief   : Shared VGA timing, colour and glyph constants plus small helpers
//           used by the digit overlay and its BCD counter.
// Rev     : 1.0  initial release
// ============================================================================
package vga_pkg;

  // 640x480@60 timing, in pixel clocks / lines
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // RGB444 pixel
  localparam int RGB_W = 12;
  typedef logic [RGB_W-1:0] rgb_t;
  localparam rgb_t COLOR_WHITE = 12'hFFF;
  localparam rgb_t COLOR_BLACK = 12'h000;

  // Glyph geometry: one ROM word per glyph row, MSB is the leftmost pixel
  localparam int GLYPH_W = 12;
  localparam int GLYPH_H = 16;

  // One BCD digit
  localparam int BCD_W = 4;
  typedef logic [BCD_W-1:0] bcd_t;

  // Sync/enable bundle carried down the pixel pipeline
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  // Blanked, syncs inactive (active-low)
  localparam sync_t SYNC_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1};

  // Next BCD digit value; 9 (or any illegal code) rolls over to 0
  function automatic bcd_t bcd_next(input bcd_t d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter.sv
`default_nettype none
// ============================================================================
// Module : bcd_counter
// Brief  : N-digit BCD up-counter with ripple carry; digit 0 is the least
//          significant and sits in value[3:0]. Wraps from all-nines to zero.
// Rev    : 1.0  initial release
// ============================================================================
module bcd_counter
  import vga_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inc,
  output logic [BCD_W*N_DIGITS-1:0] value
);

  bcd_t                r_digit [N_DIGITS];
  logic [N_DIGITS-1:0] w_carry;

  // The increment request enters at the least significant digit
  assign w_carry[0] = inc;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    // Each digit advances when a carry reaches it
    always_ff @(posedge clk) begin
      if (rst) begin
        r_digit[i] <= '0;
      end else if (w_carry[i]) begin
        r_digit[i] <= bcd_next(r_digit[i]);
      end
    end

    assign value[BCD_W*i +: BCD_W] = r_digit[i];

    if (i < N_DIGITS - 1) begin : g_carry
      assign w_carry[i+1] = w_carry[i] & (r_digit[i] == 4'd9);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_digit_overlay.sv
`default_nettype none
// ============================================================================
// Module : vga_digit_overlay
// Brief  : Overlays a BCD seconds counter, rendered from an external font
//          ROM, onto the VGA pixel stream. Fixed 3-clock latency from the
//          timing inputs to rgb and the delayed syncs.
// Rev    : 1.0  initial release
// ============================================================================
module vga_digit_overlay #(
  parameter int           ADDR_WIDTH = 8,
  parameter int           DATA_WIDTH = vga_pkg::GLYPH_W,
  parameter int           GLYPH_H    = vga_pkg::GLYPH_H,
  parameter int           N_DIGITS   = 4,
  parameter int           X0         = 280,
  parameter int           Y0         = 232,
  parameter vga_pkg::rgb_t FG        = vga_pkg::COLOR_WHITE,
  parameter vga_pkg::rgb_t BG        = vga_pkg::COLOR_BLACK
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  de,
  input  logic                  hs,
  input  logic                  vs,
  output logic [ADDR_WIDTH-1:0] outaddr,
  input  logic [DATA_WIDTH-1:0] q,
  output vga_pkg::rgb_t         rgb,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  de_o
);
  import vga_pkg::*;

  localparam int COL_W = $clog2(DATA_WIDTH);
  localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int ROW_W = $clog2(GLYPH_H);
  localparam int VAL_W = BCD_W * N_DIGITS;

  localparam logic [9:0]       C_X_LO     = 10'(X0);
  localparam logic [9:0]       C_X_HI     = 10'(X0 + N_DIGITS * DATA_WIDTH);
  localparam logic [9:0]       C_Y_LO     = 10'(Y0);
  localparam logic [9:0]       C_Y_HI     = 10'(Y0 + GLYPH_H);
  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(DATA_WIDTH - 1);
  localparam logic [DIG_W-1:0] C_DIG_LAST = DIG_W'(N_DIGITS - 1);

  // Counter and frame-stable copy of it
  logic [VAL_W-1:0]      w_counter;
  logic [VAL_W-1:0]      r_shown;
  logic                  r_vs_prev;

  // Stage 0: position decode
  logic                  w_in_box;
  logic                  w_at_start;
  logic [COL_W-1:0]      w_cur_col;
  logic [DIG_W-1:0]      w_cur_dig;
  logic [ROW_W-1:0]      w_row;
  bcd_t                  w_bcd;
  bcd_t                  w_bcd_safe;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [COL_W-1:0]      r_col;
  logic [DIG_W-1:0]      r_dig;

  // Stages 1..3
  logic [ADDR_WIDTH-1:0] r_outaddr;
  logic [COL_W-1:0]      r_col1;
  logic [COL_W-1:0]      r_col2;
  logic                  r_in1;
  logic                  r_in2;
  sync_t                 r_sync1;
  sync_t                 r_sync2;
  sync_t                 r_sync3;
  logic                  w_pix;
  rgb_t                  w_rgb_next;
  rgb_t                  r_rgb;

  bcd_counter #(
    .N_DIGITS (N_DIGITS)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (tick),
    .value (w_counter)
  );

  // Latch the counter on the first cycle vs is seen low so a frame never tears
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_prev <= 1'b1;
      r_shown   <= '0;
    end else begin
      r_vs_prev <= vs;
      if (r_vs_prev && !vs) begin
        r_shown <= w_counter;
      end
    end
  end

  // Box test and current column/digit; the box's left edge restarts both
  always_comb begin
    w_in_box   = (x >= C_X_LO) && (x < C_X_HI) && (y >= C_Y_LO) && (y < C_Y_HI);
    w_at_start = (x == C_X_LO);
    w_cur_col  = w_at_start ? '0 : r_col;
    w_cur_dig  = w_at_start ? '0 : r_dig;
    w_row      = ROW_W'(y - C_Y_LO);
  end

  // Advance the column/digit position for the next pixel inside the box
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_dig <= '0;
    end else if (w_in_box) begin
      if (w_cur_col == C_COL_LAST) begin
        r_col <= '0;
        r_dig <= (w_cur_dig == C_DIG_LAST) ? '0 : w_cur_dig + DIG_W'(1);
      end else begin
        r_col <= w_cur_col + COL_W'(1);
        r_dig <= w_cur_dig;
      end
    end
  end

  // Pick the displayed digit (leftmost = most significant) and form its row address
  always_comb begin
    w_bcd = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_cur_dig == DIG_W'(i)) begin
        w_bcd = r_shown[BCD_W*(N_DIGITS-1-i) +: BCD_W];
      end
    end
    // Illegal codes are forced to glyph 0 so the address stays inside the ROM
    w_bcd_safe = (w_bcd > 4'd9) ? '0 : w_bcd;
    w_addr     = ADDR_WIDTH'({w_bcd_safe, {ROW_W{1'b0}}}) + ADDR_WIDTH'(w_row);
  end

  // Stage 1: ROM address plus the position tags that travel with it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outaddr <= '0;
      r_col1    <= '0;
      r_in1     <= 1'b0;
      r_sync1   <= SYNC_IDLE;
    end else begin
      r_outaddr <= w_in_box ? w_addr : '0;
      r_col1    <= w_cur_col;
      r_in1     <= w_in_box;
      r_sync1   <= '{de: de, hs: hs, vs: vs};
    end
  end

  // Stage 2: wait alongside the ROM's registered read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col2  <= '0;
      r_in2   <= 1'b0;
      r_sync2 <= SYNC_IDLE;
    end else begin
      r_col2  <= r_col1;
      r_in2   <= r_in1;
      r_sync2 <= r_sync1;
    end
  end

  // Select the glyph pixel (MSB is leftmost) and choose the colour
  always_comb begin
    w_pix = q[C_COL_LAST - r_col2];
    if (!r_sync2.de) begin
      w_rgb_next = '0;
    end else if (r_in2 && w_pix) begin
      w_rgb_next = FG;
    end else begin
      w_rgb_next = BG;
    end
  end

  // Stage 3: registered colour and the matching syncs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb   <= '0;
      r_sync3 <= SYNC_IDLE;
    end else begin
      r_rgb   <= w_rgb_next;
      r_sync3 <= r_sync2;
    end
  end

  assign outaddr = r_outaddr;
  assign rgb     = r_rgb;
  assign de_o    = r_sync3.de;
  assign hs_o    = r_sync3.hs;
  assign vs_o    = r_sync3.vs;

endmodule
`default_nettype wire

// File: tb/tb_vga_digit_overlay.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_digit_overlay
// Brief  : Directed self-checking bench for vga_digit_overlay with a
//          behavioural registered font ROM.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vga_digit_overlay;

  localparam int X0 = 280;
  localparam int Y0 = 232;

  logic        clk;
  logic        rst;
  logic        tick;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        de;
  logic        hs;
  logic        vs;
  logic [7:0]  outaddr;
  logic [11:0] q;
  logic [11:0] rgb;
  logic        hs_o;
  logic        vs_o;
  logic        de_o;

  int total;
  int bad;

  vga_digit_overlay dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .x       (x),
    .y       (y),
    .de      (de),
    .hs      (hs),
    .vs      (vs),
    .outaddr (outaddr),
    .q       (q),
    .rgb     (rgb),
    .hs_o    (hs_o),
    .vs_o    (vs_o),
    .de_o    (de_o)
  );

  always #5 clk = ~clk;

  // Font ROM contents: arbitrary pattern, rightmost pixel always blank
  function automatic logic [11:0] rom_word(input logic [7:0] a);
    return ((12'(a) * 12'd181) ^ 12'hA5A) & 12'hFFE;
  endfunction

  // Registered ROM read, one clock after the address
  always @(posedge clk) q <= rom_word(outaddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic vs_edge();
    vs = 1'b0;
    step();
    vs = 1'b1;
    step();
  endtask

  // Scan x=278..329 on row yy with shown BCD value; check address and colour
  task automatic scan(input int yy, input logic [15:0] shown);
    logic [11:0] er [52];
    logic [11:0] w;
    logic [3:0]  dv;
    int          xx, px, dg, cl, ea;
    logic        inb;
    for (int i = 0; i < 54; i++) begin
      ea = 0;
      if (i < 52) begin
        xx  = 278 + i;
        px  = xx - X0;
        inb = (px >= 0) && (px < 48) && (yy >= Y0) && (yy < Y0 + 16);
        er[i] = 12'h000;
        if (inb) begin
          dg = px / 12;
          cl = px % 12;
          dv = shown[(3 - dg) * 4 +: 4];
          ea = int'(dv) * 16 + (yy - Y0);
          w  = rom_word(8'(ea));
          er[i] = w[11 - cl] ? 12'hFFF : 12'h000;
        end
        x  = 10'(xx);
        y  = 10'(yy);
        de = 1'b1;
      end else begin
        x  = 10'd0;
        de = 1'b0;
      end
      step();
      if (i < 52) chk("outaddr", 32'(outaddr), 32'(ea));
      if (i >= 2) begin
        chk("rgb", 32'(rgb), 32'(er[i-2]));
        chk("de_o_scan", 32'(de_o), 32'd1);
      end
    end
  endtask

  initial begin
    clk   = 1'b0;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    tick  = 1'b0;
    de    = 1'b1;
    hs    = 1'b0;
    vs    = 1'b0;
    x     = 10'd0;
    y     = 10'd0;

    // Reset held three clocks with random position and active inputs
    for (int k = 0; k < 3; k++) begin
      x = 10'($urandom_range(0, 799));
      y = 10'($urandom_range(0, 524));
      step();
      chk("rst_rgb", 32'(rgb), 32'h0);
      chk("rst_de_o", 32'(de_o), 32'h0);
      chk("rst_hs_o", 32'(hs_o), 32'h1);
      chk("rst_vs_o", 32'(vs_o), 32'h1);
      chk("rst_outaddr", 32'(outaddr), 32'h0);
    end
    rst = 1'b0;
    de  = 1'b0;
    hs  = 1'b1;
    vs  = 1'b1;
    x   = 10'd0;
    y   = 10'd0;
    repeat (3) step();

    // One-cycle de/hs/vs pulse at (0,0) appears exactly 3 clocks later
    de = 1'b1;
    hs = 1'b0;
    vs = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      de = 1'b0;
      hs = 1'b1;
      vs = 1'b1;
      chk("lat_de_o", 32'(de_o), 32'(k == 3));
      chk("lat_hs_o", 32'(hs_o), 32'(k != 3));
      chk("lat_vs_o", 32'(vs_o), 32'(k != 3));
      chk("lat_rgb", 32'(rgb), 32'h0);
    end

    // Counter to 1234, latch, render row 5
    tick_n(1234);
    vs_edge();
    scan(Y0 + 5, 16'h1234);

    // Mid-frame tick does not change the rendered value
    y = 10'(Y0 + 8);
    tick_n(1);
    scan(Y0 + 9, 16'h1234);
    vs_edge();
    scan(Y0, 16'h1235);
    scan(Y0 - 1, 16'h1235);
    scan(Y0 + 16, 16'h1235);

    // Tick in the latch cycle: latch keeps the pre-increment value
    vs   = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    vs   = 1'b1;
    step();
    scan(Y0 + 15, 16'h1235);
    vs_edge();
    scan(Y0 + 3, 16'h1236);

    // Climb to 9999 then wrap to 0000
    tick_n(9999 - 1236);
    vs_edge();
    scan(Y0, 16'h9999);
    tick_n(1);
    vs_edge();
    scan(Y0, 16'h0000);

    // Reset in the middle of active video
    x  = 10'd300;
    y  = 10'd240;
    de = 1'b1;
    repeat (3) step();
    chk("pre_rst_de_o", 32'(de_o), 32'h1);
    rst = 1'b1;
    step();
    chk("mid_rst_de_o", 32'(de_o), 32'h0);
    chk("mid_rst_rgb", 32'(rgb), 32'h0);
    chk("mid_rst_outaddr", 32'(outaddr), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("resume_de_o", 32'(de_o), 32'(k == 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
